// File: rtl/spike_filter_array_pkg.sv
// Shared types and default sizing for the spike filter array.
package spike_filter_array_pkg;

  localparam int NFILTS_DEFAULT = 10;
  localparam int NSTATE_DEFAULT = 27;
  localparam int NTAG_DEFAULT   = 11;
  localparam int NCT_DEFAULT    = 9;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    IN_RD,
    IN_WR,
    SW_RD,
    SW_WR,
    SW_OUT
  } state_t;

endpackage

// File: rtl/spike_filter_array_state_mem.sv
// Filter state RAM: one write port, one read port with a registered (1-cycle) output.
module SpikeFilterStateMem #(
  parameter int Naddr  = 10,
  parameter int Nwidth = 27
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [Naddr-1:0]  i_wr_addr,
  input  logic [Nwidth-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [Naddr-1:0]  i_rd_addr,
  output logic [Nwidth-1:0] o_rd_data
);

  logic [Nwidth-1:0] r_mem [2**Naddr];
  logic [Nwidth-1:0] r_rd_data;

  // NOTE: the array and its read register have no reset so this maps onto block RAM;
  // the owning FSM clears the contents explicitly after reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spike_filter_array.sv
// Bank of 2**Nfilts leaky spike accumulators, decayed and reported on every tick.
// Define SPIKE_FILTER_SATURATE_EN to saturate increments instead of wrapping them.
module spike_filter_array
  import spike_filter_array_pkg::*;
#(
  parameter int Nfilts = NFILTS_DEFAULT,
  parameter int Nstate = NSTATE_DEFAULT,
  parameter int Ntag   = NTAG_DEFAULT,
  parameter int Nct    = NCT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Nfilts-1:0] i_conf_filts_used,
  input  logic [Nstate-1:0] i_conf_increment_constant,
  input  logic [Nstate-1:0] i_conf_decay_constant,
  input  logic              i_tick,
  input  logic              i_in_v,
  output logic              o_in_a,
  input  logic [Ntag-1:0]   i_in_tag,
  input  logic [Nct-1:0]    i_in_ct,
  output logic              o_out_v,
  input  logic              i_out_a,
  output logic [Nfilts-1:0] o_out_filt_idx,
  output logic [Nstate-1:0] o_out_filt_state,
  output logic              o_missed_tick
);

  localparam int NPROD = Nstate + Nct;
  localparam logic [Nfilts-1:0] LAST_IDX = '1;

  state_t            r_state, w_next_state;
  logic [Nfilts-1:0] r_idx, w_next_idx;
  logic [Nfilts-1:0] r_in_addr;
  logic [Nct-1:0]    r_in_ct;
  logic              r_pending, r_missed;
  logic [Nfilts-1:0] r_out_idx;
  logic [Nstate-1:0] r_out_state;

  logic              w_we, w_rd_en;
  logic [Nfilts-1:0] w_wr_addr, w_rd_addr;
  logic [Nstate-1:0] w_wr_data, w_rd_data;
  logic              w_in_xfer, w_tag_valid, w_start_sweep, w_last;
  logic [NPROD-1:0]  w_inc_prod;
  logic [NPROD:0]    w_inc_sum;
  logic [Nstate-1:0] w_inc_result;
  logic [2*Nstate-1:0] w_decay_prod;
  logic [Nstate-1:0] w_decay_result;
  logic              w_unused;

  assign o_in_a        = (r_state == IDLE) && !r_pending;
  assign w_in_xfer     = o_in_a && i_in_v;
  assign w_start_sweep = (r_state == IDLE) && r_pending;
  assign w_last        = (r_idx == i_conf_filts_used);
  assign w_tag_valid   = ({{Nfilts{1'b0}}, i_in_tag} <= {{Ntag{1'b0}}, i_conf_filts_used});

  assign w_inc_prod     = NPROD'(i_conf_increment_constant) * NPROD'(r_in_ct);
  assign w_inc_sum      = {1'b0, w_inc_prod} + (NPROD+1)'(w_rd_data);
  assign w_decay_prod   = (2*Nstate)'(w_rd_data) * (2*Nstate)'(i_conf_decay_constant);
  assign w_decay_result = w_decay_prod[2*Nstate-1:Nstate];

`ifdef SPIKE_FILTER_SATURATE_EN
  assign w_inc_result = (|w_inc_sum[NPROD:Nstate]) ? '1 : w_inc_sum[Nstate-1:0];
  assign w_unused     = ^w_decay_prod[Nstate-1:0];
`else
  assign w_inc_result = w_inc_sum[Nstate-1:0];
  assign w_unused     = ^{w_decay_prod[Nstate-1:0], w_inc_sum[NPROD:Nstate]};
`endif

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_we         = 1'b0;
    w_wr_addr    = r_idx;
    w_wr_data    = '0;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_idx;
    unique case (r_state)
      CLR: begin
        w_we = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next_state = IDLE;
          w_next_idx   = '0;
        end else begin
          w_next_idx = r_idx + Nfilts'(1);
        end
      end
      IDLE: begin
        if (r_pending) begin
          w_next_state = SW_RD;
          w_next_idx   = '0;
        end else if (i_in_v && w_tag_valid) begin
          w_next_state = IN_RD;
        end
      end
      IN_RD: begin
        w_rd_en      = 1'b1;
        w_rd_addr    = r_in_addr;
        w_next_state = IN_WR;
      end
      IN_WR: begin
        w_we         = 1'b1;
        w_wr_addr    = r_in_addr;
        w_wr_data    = w_inc_result;
        w_next_state = IDLE;
      end
      SW_RD: begin
        w_rd_en      = 1'b1;
        w_next_state = SW_WR;
      end
      SW_WR: begin
        w_we         = 1'b1;
        w_wr_data    = w_decay_result;
        w_next_state = SW_OUT;
      end
      SW_OUT: begin
        if (i_out_a) begin
          if (w_last) begin
            w_next_state = IDLE;
          end else begin
            w_next_idx   = r_idx + Nfilts'(1);
            w_next_state = SW_RD;
          end
        end
      end
      default: w_next_state = CLR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= CLR;
      r_idx       <= '0;
      r_in_addr   <= '0;
      r_in_ct     <= '0;
      r_pending   <= 1'b0;
      r_missed    <= 1'b0;
      r_out_idx   <= '0;
      r_out_state <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      if (w_in_xfer) begin
        r_in_addr <= i_in_tag[Nfilts-1:0];
        r_in_ct   <= i_in_ct;
      end
      if (r_state == SW_WR) begin
        r_out_idx   <= r_idx;
        r_out_state <= w_decay_result;
      end
      if (i_tick) r_pending <= 1'b1;
      else if (w_start_sweep) r_pending <= 1'b0;
      // A tick that lands on an already-pending sweep is lost unless that sweep starts now.
      if (i_tick && r_pending && !w_start_sweep) r_missed <= 1'b1;
    end
  end

  SpikeFilterStateMem #(
    .Naddr  (Nfilts),
    .Nwidth (Nstate)
  ) u_state_mem (
    .clk       (clk),
    .i_we      (w_we && reset),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign o_out_v          = (r_state == SW_OUT);
  assign o_out_filt_idx   = r_out_idx;
  assign o_out_filt_state = r_out_state;
  assign o_missed_tick    = r_missed;

endmodule

// File: tb/tb_spike_filter_array.sv
// Self-checking bench for spike_filter_array against an array-based behavioural model.
module tb_spike_filter_array;

  localparam int NF = 10;
  localparam int NS = 27;
  localparam int NT = 11;
  localparam int NC = 9;
  localparam longint unsigned SMAX = (64'd1 << NS) - 64'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] conf_fu = '0;
  logic [NS-1:0] conf_inc = '0;
  logic [NS-1:0] conf_dec = '0;
  logic          tick = 1'b0;
  logic          in_v = 1'b0;
  logic          in_a;
  logic [NT-1:0] in_tag = '0;
  logic [NC-1:0] in_ct = '0;
  logic          out_v;
  logic          out_a = 1'b0;
  logic [NF-1:0] out_idx;
  logic [NS-1:0] out_state;
  logic          missed;

  int n_checks = 0;
  int n_pass   = 0;

  longint unsigned model_mem [2**NF];
  logic [NF-1:0] exp_idx[$];
  logic [NS-1:0] exp_st[$];
  logic [NF-1:0] obs_idx[$];
  logic [NS-1:0] obs_st[$];

  always #5 clk = ~clk;

  spike_filter_array dut (
    .clk                       (clk),
    .reset                     (reset),
    .i_conf_filts_used         (conf_fu),
    .i_conf_increment_constant (conf_inc),
    .i_conf_decay_constant     (conf_dec),
    .i_tick                    (tick),
    .i_in_v                    (in_v),
    .o_in_a                    (in_a),
    .i_in_tag                  (in_tag),
    .i_in_ct                   (in_ct),
    .o_out_v                   (out_v),
    .i_out_a                   (out_a),
    .o_out_filt_idx            (out_idx),
    .o_out_filt_state          (out_state),
    .o_missed_tick             (missed)
  );

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < 2**NF; i++) model_mem[i] = 0;
  endfunction

  function automatic void model_spike(input int tag, input int ct);
    longint unsigned s;
    if (tag > int'(conf_fu)) return;
    s = model_mem[tag] + longint'(conf_inc) * longint'(ct);
`ifdef SPIKE_FILTER_SATURATE_EN
    if (s > SMAX) s = SMAX;
`else
    s = s % (SMAX + 1);
`endif
    model_mem[tag] = s;
  endfunction

  function automatic void model_sweep();
    for (int i = 0; i <= int'(conf_fu); i++) begin
      model_mem[i] = (model_mem[i] * longint'(conf_dec)) >> NS;
      exp_idx.push_back(NF'(i));
      exp_st.push_back(NS'(model_mem[i]));
    end
  endfunction

  // ---------------- stimulus helpers (all start and end on a negedge) ----------------
  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic send_spike(input int tag, input int ct);
    int n = 0;
    in_v = 1'b1;
    in_tag = NT'(tag);
    in_ct = NC'(ct);
    while (!in_a && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!in_a) $display("FAIL spike_accept tag=%0d: in.a got 0 want 1 within 5000 cycles", tag);
    else n_pass++;
    @(negedge clk);
    in_v = 1'b0;
    model_spike(tag, ct);
  endtask

  task automatic wait_out_v(input string name);
    int n = 0;
    while (!out_v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_v) begin
      n_checks++;
      $display("FAIL %s: out.v got 0 want 1 within 200 cycles", name);
    end
  endtask

  task automatic collect(input int n, input int max_stall);
    for (int k = 0; k < n; k++) begin
      wait_out_v("collect");
      if (!out_v) return;
      obs_idx.push_back(out_idx);
      obs_st.push_back(out_state);
      repeat ($urandom_range(max_stall, 0)) @(negedge clk);
      out_a = 1'b1;
      @(negedge clk);
      out_a = 1'b0;
    end
  endtask

  task automatic wait_clear_done(input string name);
    int n = 0;
    while (!in_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 2**NF) $display("FAIL %s: in.a rose after %0d cycles want %0d", name, n, 2**NF);
    else n_pass++;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_a !== 1'b0) $display("FAIL reset_in_a: got %b want 0", in_a); else n_pass++;
    n_checks++;
    if (out_v !== 1'b0) $display("FAIL reset_out_v: got %b want 0", out_v); else n_pass++;
    n_checks++;
    if (out_idx !== '0) $display("FAIL reset_out_idx: got %0d want 0", out_idx); else n_pass++;
    n_checks++;
    if (out_state !== '0) $display("FAIL reset_out_state: got %0d want 0", out_state); else n_pass++;
    n_checks++;
    if (missed !== 1'b0) $display("FAIL reset_missed: got %b want 0", missed); else n_pass++;
    reset = 1'b1;
    wait_clear_done("reset_clear_len");
    conf_fu = NF'(3);
    conf_dec = NS'($urandom);
    pulse_tick();
    model_sweep();
    collect(4, 0);
    n_checks++;
    if (obs_idx.size() !== exp_idx.size())
      $display("FAIL reset_sweep_len: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else n_pass++;
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_checks++;
      if (obs_idx[k] !== exp_idx[k] || obs_st[k] !== exp_st[k])
        $display("FAIL reset_sweep[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_idx[k], obs_st[k], exp_idx[k], exp_st[k]);
      else n_pass++;
    end
    exp_idx.delete(); exp_st.delete(); obs_idx.delete(); obs_st.delete();
  endtask

  task automatic test_basic();
    conf_fu = NF'(1);
    conf_inc = NS'(1000);
    conf_dec = NS'(1 << 26);
    send_spike(1, 3);
    pulse_tick();
    model_sweep();
    collect(2, 0);
    n_checks++;
    if (obs_idx.size() !== exp_idx.size())
      $display("FAIL basic_sweep_len: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else n_pass++;
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_checks++;
      if (obs_idx[k] !== exp_idx[k] || obs_st[k] !== exp_st[k])
        $display("FAIL basic_sweep[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_idx[k], obs_st[k], exp_idx[k], exp_st[k]);
      else n_pass++;
    end
    exp_idx.delete(); exp_st.delete(); obs_idx.delete(); obs_st.delete();
  endtask

  task automatic test_stall();
    conf_fu = NF'(3);
    conf_inc = NS'(777);
    conf_dec = NS'(100_000_000);
    send_spike(0, 7);
    send_spike(3, 2);
    pulse_tick();
    model_sweep();
    wait_out_v("stall_first");
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (out_v !== 1'b1 || out_idx !== exp_idx[0] || out_state !== exp_st[0])
        $display("FAIL stall_hold c=%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", c, out_v, out_idx, out_state, exp_idx[0], exp_st[0]);
      else n_pass++;
      @(negedge clk);
    end
    collect(4, 3);
    n_checks++;
    if (obs_idx.size() !== exp_idx.size())
      $display("FAIL stall_sweep_len: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else n_pass++;
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_checks++;
      if (obs_idx[k] !== exp_idx[k] || obs_st[k] !== exp_st[k])
        $display("FAIL stall_sweep[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_idx[k], obs_st[k], exp_idx[k], exp_st[k]);
      else n_pass++;
    end
    exp_idx.delete(); exp_st.delete(); obs_idx.delete(); obs_st.delete();
  endtask

  task automatic test_discard_and_single();
    int seen = 0;
    conf_fu = NF'(3);
    conf_inc = NS'(500);
    conf_dec = NS'(120_000_000);
    send_spike(5, 4);
    send_spike(1025, 4);
    send_spike(2, 0);
    pulse_tick();
    model_sweep();
    collect(4, 1);
    conf_fu = '0;
    send_spike(0, 9);
    pulse_tick();
    model_sweep();
    collect(1, 1);
    repeat (20) begin
      @(negedge clk);
      if (out_v) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL discard_extra_out: got %0d extra outputs want 0", seen); else n_pass++;
    n_checks++;
    if (obs_idx.size() !== exp_idx.size())
      $display("FAIL discard_sweep_len: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else n_pass++;
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_checks++;
      if (obs_idx[k] !== exp_idx[k] || obs_st[k] !== exp_st[k])
        $display("FAIL discard_sweep[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_idx[k], obs_st[k], exp_idx[k], exp_st[k]);
      else n_pass++;
    end
    exp_idx.delete(); exp_st.delete(); obs_idx.delete(); obs_st.delete();
  endtask

  task automatic test_saturate();
    conf_fu = NF'(3);
    conf_dec = '0;
    pulse_tick();
    model_sweep();
    collect(4, 0);
    conf_inc = NS'(1 << 26);
    send_spike(2, 3);
    conf_dec = NS'(SMAX);
    pulse_tick();
    model_sweep();
    collect(4, 0);
    n_checks++;
    if (obs_idx.size() !== exp_idx.size())
      $display("FAIL sat_sweep_len: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else n_pass++;
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_checks++;
      if (obs_idx[k] !== exp_idx[k] || obs_st[k] !== exp_st[k])
        $display("FAIL sat_sweep[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_idx[k], obs_st[k], exp_idx[k], exp_st[k]);
      else n_pass++;
    end
    exp_idx.delete(); exp_st.delete(); obs_idx.delete(); obs_st.delete();
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      conf_fu = NF'($urandom_range(7, 0));
      conf_inc = ($urandom_range(1, 0) == 1) ? NS'($urandom) : NS'($urandom_range(5000, 0));
      conf_dec = NS'($urandom);
      repeat ($urandom_range(4, 0))
        send_spike($urandom_range(int'(conf_fu) + 2, 0), $urandom_range(2**NC - 1, 0));
      pulse_tick();
      model_sweep();
      collect(int'(conf_fu) + 1, 2);
    end
    n_checks++;
    if (obs_idx.size() !== exp_idx.size())
      $display("FAIL rand_sweep_len: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else n_pass++;
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_checks++;
      if (obs_idx[k] !== exp_idx[k] || obs_st[k] !== exp_st[k])
        $display("FAIL rand_sweep[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_idx[k], obs_st[k], exp_idx[k], exp_st[k]);
      else n_pass++;
    end
    exp_idx.delete(); exp_st.delete(); obs_idx.delete(); obs_st.delete();
  endtask

  task automatic test_missed_tick_and_abort();
    int seen = 0;
    conf_fu = NF'(2);
    conf_dec = NS'(90_000_000);
    n_checks++;
    if (missed !== 1'b0) $display("FAIL missed_initial: got %b want 0", missed); else n_pass++;
    pulse_tick();
    wait_out_v("missed_first");
    pulse_tick();
    n_checks++;
    if (missed !== 1'b0) $display("FAIL missed_after_one: got %b want 0", missed); else n_pass++;
    pulse_tick();
    n_checks++;
    if (missed !== 1'b1) $display("FAIL missed_after_two: got %b want 1", missed); else n_pass++;
    model_sweep();
    model_sweep();
    collect(6, 1);
    repeat (20) begin
      @(negedge clk);
      if (out_v) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL missed_extra_sweep: got %0d extra outputs want 0", seen); else n_pass++;
    n_checks++;
    if (missed !== 1'b1) $display("FAIL missed_sticky: got %b want 1", missed); else n_pass++;
    // abort a stalled sweep with reset; the full clear must restart
    conf_inc = NS'(4321);
    send_spike(1, 5);
    pulse_tick();
    wait_out_v("abort_first");
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_v !== 1'b0 || in_a !== 1'b0 || missed !== 1'b0)
      $display("FAIL abort_reset: got v=%b a=%b missed=%b want 0 0 0", out_v, in_a, missed);
    else n_pass++;
    reset = 1'b1;
    wait_clear_done("abort_clear_len");
    pulse_tick();
    model_sweep();
    collect(3, 0);
    n_checks++;
    if (obs_idx.size() !== exp_idx.size())
      $display("FAIL missed_sweep_len: got %0d want %0d", obs_idx.size(), exp_idx.size());
    else n_pass++;
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
      n_checks++;
      if (obs_idx[k] !== exp_idx[k] || obs_st[k] !== exp_st[k])
        $display("FAIL missed_sweep[%0d]: got (%0d,%0d) want (%0d,%0d)", k, obs_idx[k], obs_st[k], exp_idx[k], exp_st[k]);
      else n_pass++;
    end
    exp_idx.delete(); exp_st.delete(); obs_idx.delete(); obs_st.delete();
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_discard_and_single();
    test_saturate();
    test_random();
    test_missed_tick_and_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spike_filter_array.md
SPIKE_FILTER_ARRAY -- requirements
Module: spike_filter_array

Interface
REQ-001 SHALL have parameter Nfilts, default 10, meaning filter index width (2**Nfilts filters).
REQ-002 SHALL have parameter Nstate, default 27, meaning filter state width.
REQ-003 SHALL have parameter Ntag, default 11, meaning input tag width.
REQ-004 SHALL have parameter Nct, default 9, meaning input count width.
REQ-005 SHALL use one clock and a synchronous active-low reset; clk  input  1  clock.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 conf  SpikeFilterConf #(Nfilts,Nstate)  -  filts_used, increment_constant, decay_constant.
REQ-008 tick  input  1  one-cycle time-unit pulse from the time manager.
REQ-009 in  TagCtChannel #(Ntag,Nct)  consumer  spike tag (filter index) and count.
REQ-010 out  SpikeFilterOutputChannel #(Nfilts,Nstate)  producer  per-filter state report.
REQ-011 missed_tick  output  1  sticky flag: tick lost because a sweep was still pending.

Function
REQ-012 SHALL hold 2**Nfilts states of Nstate bits in a 1-cycle-read-latency RAM.
REQ-013 SHALL run FSM states CLR, IDLE, IN_RD, IN_WR, SW_RD, SW_WR, SW_OUT.
REQ-014 CLR: write 0 to every address 0..2**Nfilts-1, one per cycle, then go to IDLE.
REQ-015 Handshake: transfer occurs when v && a; in.a SHALL be 1 only in IDLE with no pending sweep.
REQ-016 IDLE with pending tick SHALL enter SW_RD at index 0; pending sweep has priority over an input offered the same cycle.
REQ-017 Input transfer: IDLE -> IN_RD (read state[tag[Nfilts-1:0]]) -> IN_WR (write state + increment_constant*ct) -> IDLE; 3 cycles per spike.
REQ-018 Tag with tag > filts_used (full Ntag-bit compare) SHALL be accepted and discarded with no state change.
REQ-019 ct = 0 SHALL leave state unchanged.
REQ-020 Increment product SHALL be formed at Nstate+Nct bits before add; overflow handling per REQ-030.
REQ-021 Sweep: SW_RD reads index i; SW_WR writes (state*decay_constant)>>Nstate (2*Nstate-bit product, truncated); SW_OUT drives out.v=1, filt_idx=i, filt_state=decayed value.
REQ-022 out fields SHALL hold stable while out.v=1 && out.a=0.
REQ-023 On out transfer: if i == filts_used go to IDLE, else i+1 and SW_RD.
REQ-024 filts_used = 0 SHALL sweep exactly one filter (index 0).
REQ-025 tick SHALL set a one-deep pending flag, cleared on entry to SW_RD at index 0; a tick arriving while pending is already set SHALL set missed_tick.
REQ-026 conf changes mid-sweep SHALL take effect from the next RAM access; no glitch protection required.

Reset
REQ-027 reset=0 at a clock edge SHALL force FSM to CLR at index 0, out.v=0, in.a=0, pending=0, missed_tick=0.
REQ-028 Reset mid-sweep or mid-update SHALL abort the operation and restart the full clear; no partial output transfer completes.
REQ-029 Reset values: out.v=0, out.filt_idx=0, out.filt_state=0, in.a=0, missed_tick=0.

Configuration
REQ-030 Macro SPIKE_FILTER_SATURATE_EN: defined -> increment saturates at 2**Nstate-1; undefined -> sum wraps modulo 2**Nstate.

Structure
REQ-031 Shared package SHALL hold the FSM state enum and default Nfilts/Nstate/Ntag/Nct constants.
REQ-032 State RAM SHALL be sub-module SpikeFilterStateMem (1 write port, 1 registered read port).

Verification
REQ-033 Reset then wait 2**Nfilts cycles -> in.a rises only after clear; sweep with filts_used=3 reports states 0,0,0,0 for idx 0..3.
REQ-034 increment=1000, decay=2**26 (0.5), filts_used=1; spike tag=1 ct=3, tick -> outputs (0,0),(1,1500).
REQ-035 out.a held low 10 cycles during sweep -> out fields unchanged, no further RAM writes, then sweep resumes.
REQ-036 tag=5 with filts_used=3 -> accepted, next sweep shows only idx 0..3, all unchanged.
REQ-037 increment=2**26, ct=3 on zero state -> SATURATE_EN: 2**27-1; without: 2**26 (wrapped).
REQ-038 Two ticks during one long stalled sweep -> one extra sweep runs, missed_tick=1 until reset.
